usbdev_ep_buffer: RTL and testbench
===================================

# usbdev_ep_buffer

Parametrised multi-endpoint packet buffer for the USB device core, sitting between the packet engine (RX byte stream) and the endpoint/application side. It generalises the existing single-endpoint byte buffering to EP_COUNT independent circular FIFOs. Each FIFO supports packet-level commit/abort, so bytes from a packet that fails CRC are never exposed to the reader. It also provides per-endpoint level, flush and sticky overflow reporting.

## Interface
- EP_COUNT, 4: number of endpoints, 1..16.
- DEPTH, 16: bytes per endpoint FIFO; power of two, at least 2.
- DATA_W, 8: data width.
- Derived: AW = log2(DEPTH); EW = max(1, ceil(log2(EP_COUNT))).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; sampled on clk.
- wr_ep  in  EW  endpoint selected for write, commit and abort.
- wr_valid  in  1  write strobe for wr_data.
- wr_data  in  DATA_W  byte to append.
- wr_ready  out  1  the selected endpoint is not full.
- wr_commit  in  1  end of a good packet on wr_ep.
- wr_abort  in  1  discard the uncommitted packet on wr_ep.
- rd_ep  in  EW  endpoint selected for read.
- rd_valid  out  1  the selected endpoint has a committed byte.
- rd_data  out  DATA_W  head byte of the selected endpoint.
- rd_ready  in  1  pop when rd_valid && rd_ready.
- flush  in  EP_COUNT  per-endpoint flush pulse.
- ep_nonempty  out  EP_COUNT  committed level != 0, one bit per endpoint.
- ep_level  out  EP_COUNT*(AW+1)  committed byte count; endpoint i occupies bits [i*(AW+1) +: AW+1].
- ep_overflow  out  EP_COUNT  sticky: a write was attempted while full.

## Operation
- Each endpoint keeps three AW+1-bit pointers, with the MSB as the wrap bit: wp (speculative write), cp (committed), rp (read).
- Full: wp - rp == DEPTH. Readable: cp != rp. ep_level = cp - rp, computed modulo 2^(AW+1).
- Write: wr_valid && wr_ready stores the byte at mem[wp[AW-1:0]] and increments wp.
- Write while full: the byte is dropped, ep_overflow is set, and the current packet is marked poisoned.
- Commit: cp <= wp, where wp includes any byte accepted in the same cycle. A commit on a poisoned packet behaves as an abort and clears the poison flag.
- Abort: wp <= cp. Any byte written in the same cycle is discarded and the poison flag is cleared.
- wr_abort together with wr_commit: the abort wins.
- Read: rd_valid and rd_data are combinational from rd_ep, rp and mem. A pop increments rp.
- Read and write on the same endpoint in the same cycle are both honoured. A pop frees space that is visible to wr_ready from the next cycle.
- flush[i]: wp, cp and rp of endpoint i go to 0, and ep_overflow[i] and the poison flag clear. Flush overrides a write, commit, abort or pop on that endpoint in the same cycle.
- An out-of-range wr_ep or rd_ep (at or above EP_COUNT) gives wr_ready=0 and rd_valid=0; writes, commits and pops to it are ignored.

## Timing
- Reset values: all pointers 0, wr_ready=1, rd_valid=0, rd_data=mem[0] (don't-care), ep_level=0, ep_nonempty=0, ep_overflow=0, poison=0. Memory contents are not reset.
- Reset during a packet discards everything, including committed data.
- Write-to-read latency: a byte becomes readable the cycle after the commit edge. If commit is in the same cycle as the last byte, that is one cycle after that byte.
- Pop latency: 0. rd_data advances on the cycle after the pop edge.
- wr_ready, rd_valid and rd_data are combinational from registered state and the select inputs. There is no combinational path from wr_valid or rd_ready.
- Wrap-around: pointers wrap modulo 2^(AW+1), so a level of exactly DEPTH is full, not empty.

## Configuration
- USBDEV_EP_ROLLBACK_EN defined: commit, abort and poison behaviour as described above.
- USBDEV_EP_ROLLBACK_EN undefined:
  - cp is not implemented; it is tied to wp, so a byte is readable the cycle after it is written.
  - wr_commit and wr_abort are ignored. There is no poison flag.
  - ep_overflow remains and behaves identically.

## Structure
- Shared package usbdev_ep_pkg: ep_ptr_t (AW+1 bits), a pointer-difference function, and EW/AW derivation constants.
- Sub-module usbdev_ep_fifo_chan: one endpoint with its pointers, memory, poison and overflow flags. It is instantiated EP_COUNT times.
- The top level does only select decode and output muxing.

## Test plan
- After reset, write 0x11,0x22,0x33 to EP1, then commit -> rd_valid=0 until the commit edge, then reads return 0x11,0x22,0x33 and ep_level[EP1] steps 3,2,1,0.
- Write 5 bytes to EP2, then abort -> ep_level[EP2]=0 and rd_valid=0. A following write of 0xA5 and commit reads back 0xA5.
- DEPTH=16: write 17 bytes to EP0, then commit -> wr_ready=0 after 16 bytes, ep_overflow[0]=1, ep_level[0]=0 because the poisoned packet is discarded. flush[0] clears ep_overflow[0].
- Fill and drain EP3 40 times with 7-byte packets, interleaving reads on the same cycles -> data order preserved across the pointer wrap, and level never exceeds 16.
- Commit and abort in the same cycle on EP1 with 4 pending bytes -> nothing is committed. Flush and pop in the same cycle on EP0 -> EP0 is empty afterwards.
- Build without USBDEV_EP_ROLLBACK_EN: a write to EP0 gives rd_valid=1 the next cycle, and wr_commit/wr_abort have no effect.

Source files
------------

// File: rtl/usbdev_ep_pkg.sv
// Shared types, derivation helpers and pointer arithmetic for the USB endpoint packet buffer.
// Optional packet rollback (commit/abort/poison) is enabled by USBDEV_EP_ROLLBACK_EN.
package usbdev_ep_pkg;

    localparam int EP_COUNT_DEF = 4;
    localparam int DEPTH_DEF    = 16;
    localparam int DATA_W_DEF   = 8;
    localparam int PTR_MAX_W    = 16;

    function automatic int ep_aw(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int ep_ew(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    localparam int AW_DEF = ep_aw(DEPTH_DEF);
    localparam int EW_DEF = ep_ew(EP_COUNT_DEF);

    typedef logic [AW_DEF:0] ep_ptr_t;

    // Wrap-bit pointers subtract modulo 2^(AW+1); callers truncate to their own pointer width.
    function automatic logic [PTR_MAX_W-1:0] ep_ptr_diff(input logic [PTR_MAX_W-1:0] a,
                                                         input logic [PTR_MAX_W-1:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/usbdev_ep_fifo_chan.sv
// One endpoint circular FIFO with speculative write, committed and read pointers.
// Commit/abort/poison are present only when USBDEV_EP_ROLLBACK_EN is defined.
module usbdev_ep_fifo_chan
    import usbdev_ep_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int AW    = ep_aw(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_commit,
    input  logic              wr_abort,
    input  logic              rd_pop,
    input  logic              flush,
    output logic              full,
    output logic              readable,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       level,
    output logic              overflow
);

    logic [AW:0]       wp_q, wp_d, rp_q, rp_d, cp_s, wp_inc_s, fill_s;
    logic              ovf_q, ovf_d;
    logic              wr_ok_s, wr_drop_s, pop_s;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign fill_s    = (AW+1)'(ep_ptr_diff(PTR_MAX_W'(wp_q), PTR_MAX_W'(rp_q)));
    assign level     = (AW+1)'(ep_ptr_diff(PTR_MAX_W'(cp_s), PTR_MAX_W'(rp_q)));
    assign full      = (fill_s == (AW+1)'(DEPTH));
    assign readable  = (cp_s != rp_q);
    assign rd_data   = mem_q[rp_q[AW-1:0]];
    assign overflow  = ovf_q;
    assign wr_ok_s   = wr_en & ~full;
    assign wr_drop_s = wr_en & full;
    assign pop_s     = rd_pop & readable;
    assign wp_inc_s  = wp_q + {{AW{1'b0}}, wr_ok_s};

`ifdef USBDEV_EP_ROLLBACK_EN
    logic [AW:0] cp_q, cp_d;
    logic        poison_q, poison_d;

    assign cp_s = cp_q;

    // Next pointer/flag state; flush dominates, then abort (or poisoned commit), then commit.
    always_comb begin
        wp_d     = wp_inc_s;
        rp_d     = rp_q + {{AW{1'b0}}, pop_s};
        cp_d     = cp_q;
        ovf_d    = ovf_q | wr_drop_s;
        poison_d = poison_q | wr_drop_s;
        if (flush) begin
            wp_d     = '0;
            rp_d     = '0;
            cp_d     = '0;
            ovf_d    = 1'b0;
            poison_d = 1'b0;
        end else if (wr_abort || (wr_commit && poison_d)) begin
            wp_d     = cp_q;
            poison_d = 1'b0;
        end else if (wr_commit) begin
            cp_d = wp_inc_s;
        end else begin
            cp_d = cp_q;
        end
    end

    // Committed pointer and poison flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cp_q     <= '0;
            poison_q <= 1'b0;
        end else begin
            cp_q     <= cp_d;
            poison_q <= poison_d;
        end
    end
`else
    logic unused_rollback_s;

    assign cp_s              = wp_q;
    assign unused_rollback_s = wr_commit ^ wr_abort;

    // Next pointer/flag state without rollback: written bytes are immediately committed.
    always_comb begin
        wp_d  = wp_inc_s;
        rp_d  = rp_q + {{AW{1'b0}}, pop_s};
        ovf_d = ovf_q | wr_drop_s;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q | wr_drop_s;
        end
    end
`endif

    // Write/read pointers and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            ovf_q <= ovf_d;
        end
    end

    // Byte storage is not reset; a byte written during an abort is simply never exposed.
    always_ff @(posedge clk) begin
        if (wr_ok_s && !flush) begin
            mem_q[wp_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/usbdev_ep_buffer.sv
// Multi-endpoint packet buffer: endpoint select decode and output muxing over EP_COUNT FIFOs.
// Packet commit/abort rollback is enabled by defining USBDEV_EP_ROLLBACK_EN.
module usbdev_ep_buffer
    import usbdev_ep_pkg::*;
#(
    parameter int EP_COUNT = EP_COUNT_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    localparam int AW      = ep_aw(DEPTH),
    localparam int EW      = ep_ew(EP_COUNT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [EW-1:0]            wr_ep,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     wr_commit,
    input  logic                     wr_abort,
    input  logic [EW-1:0]            rd_ep,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     rd_ready,
    input  logic [EP_COUNT-1:0]      flush,
    output logic [EP_COUNT-1:0]      ep_nonempty,
    output logic [EP_COUNT*(AW+1)-1:0] ep_level,
    output logic [EP_COUNT-1:0]      ep_overflow
);

    logic [EP_COUNT-1:0] full_s, readable_s;
    logic [DATA_W-1:0]   chan_data_s [EP_COUNT];
    logic                wr_in_range_s, rd_in_range_s;

    assign wr_in_range_s = (32'(wr_ep) < EP_COUNT);
    assign rd_in_range_s = (32'(rd_ep) < EP_COUNT);

    for (genvar i = 0; i < EP_COUNT; i++) begin : g_chan
        logic [AW:0] level_s;

        usbdev_ep_fifo_chan #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .wr_en     (wr_valid && (wr_ep == EW'(i))),
            .wr_data   (wr_data),
            .wr_commit (wr_commit && (wr_ep == EW'(i))),
            .wr_abort  (wr_abort && (wr_ep == EW'(i))),
            .rd_pop    (rd_ready && (rd_ep == EW'(i))),
            .flush     (flush[i]),
            .full      (full_s[i]),
            .readable  (readable_s[i]),
            .rd_data   (chan_data_s[i]),
            .level     (level_s),
            .overflow  (ep_overflow[i])
        );

        assign ep_level[i*(AW+1) +: AW+1] = level_s;
        assign ep_nonempty[i]             = readable_s[i];
    end

    // Select the addressed endpoint; out-of-range selects look full and empty.
    always_comb begin
        rd_data = chan_data_s[0];
        if (wr_in_range_s) begin
            wr_ready = ~full_s[wr_ep];
        end else begin
            wr_ready = 1'b0;
        end
        if (rd_in_range_s) begin
            rd_valid = readable_s[rd_ep];
            rd_data  = chan_data_s[rd_ep];
        end else begin
            rd_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_usbdev_ep_buffer.sv
// Directed self-checking bench for usbdev_ep_buffer, covering both the default build and
// the USBDEV_EP_ROLLBACK_EN build.
module tb_usbdev_ep_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wr_ep, rd_ep;
    logic        wr_valid, wr_commit, wr_abort, rd_ready;
    logic [7:0]  wr_data;
    logic [3:0]  flush;
    logic        wr_ready, rd_valid;
    logic [7:0]  rd_data;
    logic [3:0]  ep_nonempty, ep_overflow;
    logic [19:0] ep_level;

    int checks   = 0;
    int failures = 0;

    usbdev_ep_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ep       (wr_ep),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .wr_commit   (wr_commit),
        .wr_abort    (wr_abort),
        .rd_ep       (rd_ep),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .flush       (flush),
        .ep_nonempty (ep_nonempty),
        .ep_level    (ep_level),
        .ep_overflow (ep_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] lvl(input int ep);
        return ep_level[ep*5 +: 5];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid  = 1'b0;
        wr_commit = 1'b0;
        wr_abort  = 1'b0;
        rd_ready  = 1'b0;
        flush     = 4'b0000;
    endtask

    logic [7:0] q[$];
    logic [7:0] pend[$];
    logic [7:0] exp3 [3];
    logic [7:0] b;

    initial begin
        idle();
        wr_ep   = 2'd0;
        rd_ep   = 2'd0;
        wr_data = 8'h00;
        reset   = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_level", 32'(ep_level), 32'd0);
        chk("rst_nonempty", 32'(ep_nonempty), 32'd0);
        chk("rst_overflow", 32'(ep_overflow), 32'd0);

`ifdef USBDEV_EP_ROLLBACK_EN
        // EP1: three bytes, commit, then read back
        exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
        rd_ep = 2'd1;
        wr_ep = 2'd1;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = exp3[i];
            #1;
            chk("ep1_precommit_rv", 32'(rd_valid), 32'd0);
            cyc();
        end
        wr_valid  = 1'b0;
        wr_commit = 1'b1;
        #1;
        chk("ep1_commit_cycle_rv", 32'(rd_valid), 32'd0);
        cyc();
        idle();
        #1;
        chk("ep1_postcommit_rv", 32'(rd_valid), 32'd1);
        chk("ep1_nonempty", 32'(ep_nonempty), 32'b0010);
        for (int i = 0; i < 3; i++) begin
            chk("ep1_rd_data", 32'(rd_data), 32'(exp3[i]));
            chk("ep1_level", 32'(lvl(1)), 32'(3 - i));
            rd_ready = 1'b1;
            cyc();
            rd_ready = 1'b0;
            #1;
        end
        chk("ep1_drained_level", 32'(lvl(1)), 32'd0);
        chk("ep1_drained_rv", 32'(rd_valid), 32'd0);

        // EP2: five bytes then abort; then a single byte committed with it
        wr_ep = 2'd2;
        rd_ep = 2'd2;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i + 1);
            cyc();
        end
        wr_valid = 1'b0;
        wr_abort = 1'b1;
        cyc();
        idle();
        #1;
        chk("ep2_abort_level", 32'(lvl(2)), 32'd0);
        chk("ep2_abort_rv", 32'(rd_valid), 32'd0);
        wr_valid  = 1'b1;
        wr_data   = 8'hA5;
        wr_commit = 1'b1;
        cyc();
        idle();
        #1;
        chk("ep2_a5_rv", 32'(rd_valid), 32'd1);
        chk("ep2_a5_data", 32'(rd_data), 32'hA5);
        chk("ep2_a5_level", 32'(lvl(2)), 32'd1);
        rd_ready = 1'b1;
        cyc();
        idle();

        // EP0: 17 bytes overflow a 16-deep FIFO; the commit is turned into an abort
        wr_ep = 2'd0;
        rd_ep = 2'd0;
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            #1;
            chk("ep0_fill_wr_ready", 32'(wr_ready), (i < 16) ? 32'd1 : 32'd0);
            cyc();
        end
        wr_valid = 1'b0;
        #1;
        chk("ep0_overflow", 32'(ep_overflow), 32'b0001);
        wr_commit = 1'b1;
        cyc();
        idle();
        #1;
        chk("ep0_poison_level", 32'(lvl(0)), 32'd0);
        chk("ep0_poison_rv", 32'(rd_valid), 32'd0);
        chk("ep0_poison_wr_ready", 32'(wr_ready), 32'd1);
        chk("ep0_ovf_sticky", 32'(ep_overflow), 32'b0001);
        flush = 4'b0001;
        cyc();
        idle();
        #1;
        chk("ep0_flush_ovf", 32'(ep_overflow), 32'd0);
`else
        // EP0: without rollback a byte is readable the cycle after it is written
        wr_ep    = 2'd0;
        rd_ep    = 2'd0;
        wr_valid = 1'b1;
        wr_data  = 8'h11;
        #1;
        chk("nr_pre_rv", 32'(rd_valid), 32'd0);
        cyc();
        idle();
        #1;
        chk("nr_post_rv", 32'(rd_valid), 32'd1);
        chk("nr_post_data", 32'(rd_data), 32'h11);
        chk("nr_post_level", 32'(lvl(0)), 32'd1);
        wr_abort = 1'b1;
        cyc();
        idle();
        #1;
        chk("nr_abort_ignored", 32'(lvl(0)), 32'd1);
        wr_commit = 1'b1;
        cyc();
        idle();
        #1;
        chk("nr_commit_ignored", 32'(lvl(0)), 32'd1);
        rd_ready = 1'b1;
        cyc();
        idle();
        #1;
        chk("nr_pop_level", 32'(lvl(0)), 32'd0);

        // EP0: 17 writes; 16 kept, overflow sticky
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i + 8'h40);
            #1;
            chk("nr_fill_wr_ready", 32'(wr_ready), (i < 16) ? 32'd1 : 32'd0);
            cyc();
        end
        idle();
        #1;
        chk("nr_ovf", 32'(ep_overflow), 32'b0001);
        chk("nr_full_level", 32'(lvl(0)), 32'd16);
        chk("nr_full_head", 32'(rd_data), 32'h40);
        chk("nr_full_rv", 32'(rd_valid), 32'd1);
        flush = 4'b0001;
        cyc();
        idle();
        #1;
        chk("nr_flush_ovf", 32'(ep_overflow), 32'd0);
        chk("nr_flush_level", 32'(lvl(0)), 32'd0);
        chk("nr_flush_wr_ready", 32'(wr_ready), 32'd1);
`endif

        // EP3: 40 packets of 7 bytes with concurrent reads, across many pointer wraps
        wr_ep    = 2'd3;
        rd_ep    = 2'd3;
        rd_ready = 1'b1;
        q.delete();
        pend.delete();
        for (int p = 0; p < 40; p++) begin
            for (int k = 0; k < 7; k++) begin
                b         = 8'(p * 7 + k);
                wr_valid  = 1'b1;
                wr_data   = b;
                wr_commit = (k == 6);
                #1;
                chk("ep3_rv", 32'(rd_valid), (q.size() != 0) ? 32'd1 : 32'd0);
                chk("ep3_level", 32'(lvl(3)), 32'(q.size()));
                if (q.size() != 0) begin
                    chk("ep3_data", 32'(rd_data), 32'(q[0]));
                end
                cyc();
                if (q.size() != 0) begin
                    void'(q.pop_front());
                end
`ifdef USBDEV_EP_ROLLBACK_EN
                pend.push_back(b);
                if (k == 6) begin
                    q = {q, pend};
                    pend.delete();
                end
`else
                q.push_back(b);
`endif
            end
        end
        wr_valid  = 1'b0;
        wr_commit = 1'b0;
        for (int n = 0; n < 20 && q.size() != 0; n++) begin
            #1;
            chk("ep3_drain_data", 32'(rd_data), 32'(q[0]));
            cyc();
            void'(q.pop_front());
        end
        idle();
        #1;
        chk("ep3_drain_count", 32'(q.size()), 32'd0);
        chk("ep3_empty_rv", 32'(rd_valid), 32'd0);
        chk("ep3_empty_level", 32'(lvl(3)), 32'd0);

`ifdef USBDEV_EP_ROLLBACK_EN
        // EP1: commit and abort together with four pending bytes
        wr_ep = 2'd1;
        rd_ep = 2'd1;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'hE0 + i);
            cyc();
        end
        wr_valid  = 1'b0;
        wr_commit = 1'b1;
        wr_abort  = 1'b1;
        cyc();
        idle();
        #1;
        chk("ep1_ca_level", 32'(lvl(1)), 32'd0);
        chk("ep1_ca_rv", 32'(rd_valid), 32'd0);
        wr_valid  = 1'b1;
        wr_data   = 8'h5A;
        wr_commit = 1'b1;
        cyc();
        idle();
        #1;
        chk("ep1_ca_next_data", 32'(rd_data), 32'h5A);
        chk("ep1_ca_next_level", 32'(lvl(1)), 32'd1);
        rd_ready = 1'b1;
        cyc();
        idle();
`endif

        // EP0: flush and pop in the same cycle leave the endpoint empty
        wr_ep = 2'd0;
        rd_ep = 2'd0;
        wr_valid = 1'b1;
        wr_data  = 8'hC1;
        cyc();
        wr_data   = 8'hC2;
        wr_commit = 1'b1;
        cyc();
        idle();
        #1;
        chk("ep0_fp_pre_level", 32'(lvl(0)), 32'd2);
        chk("ep0_fp_pre_data", 32'(rd_data), 32'hC1);
        flush    = 4'b0001;
        rd_ready = 1'b1;
        cyc();
        idle();
        #1;
        chk("ep0_fp_level", 32'(lvl(0)), 32'd0);
        chk("ep0_fp_rv", 32'(rd_valid), 32'd0);
        chk("ep0_fp_nonempty", 32'(ep_nonempty), 32'd0);
        wr_valid  = 1'b1;
        wr_data   = 8'hD7;
        wr_commit = 1'b1;
        cyc();
        idle();
        #1;
        chk("ep0_fp_after_data", 32'(rd_data), 32'hD7);
        chk("ep0_fp_after_level", 32'(lvl(0)), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
